// File: rtl/mips_pkg.sv
// -----------------------------------------------------------------------------
// mips_pkg
// Shared definitions for the 5-stage MIPS pipeline control blocks.
//   - Opcode constants used by decode and by anything that models instructions.
//   - Forwarding mux select encodings (FWD_REG / FWD_MEM / FWD_WB).
//   - trk_entry_t: one in-flight destination record {v, rd, ld}.
//   - make_entry(): builds a record, forcing v=0 for writes to $0.
// No ports (package).
// -----------------------------------------------------------------------------
package mips_pkg;

  // MIPS has 32 architectural registers; tracker records are sized to match.
  localparam int MIPS_REG_AW = 5;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_JAL   = 6'b000011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_BNE   = 6'b000101;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;

  localparam logic [1:0] FWD_REG = 2'd0;
  localparam logic [1:0] FWD_MEM = 2'd1;
  localparam logic [1:0] FWD_WB  = 2'd2;

  typedef struct packed {
    logic                   v;
    logic [MIPS_REG_AW-1:0] rd;
    logic                   ld;
  } trk_entry_t;

  // $0 is hard-wired to zero, so a write to it can never be a hazard source.
  // Killing it here keeps every comparator downstream free of an rd!=0 term.
  function automatic trk_entry_t make_entry(input logic                   v,
                                            input logic [MIPS_REG_AW-1:0] rd,
                                            input logic                   ld);
    trk_entry_t e;
    e.v  = v & (rd != '0);
    e.rd = rd;
    e.ld = ld & e.v;
    return e;
  endfunction

endpackage

// File: rtl/dst_tracker.sv
// -----------------------------------------------------------------------------
// dst_tracker
// Three-deep shift register of destination records for the instructions
// currently in EX, MEM and WB. Every cycle WB<=MEM, MEM<=EX and EX takes the
// instruction leaving ID, or an empty slot when a bubble/flush is inserted.
// Ports:
//   clk, rst      clock, synchronous active-high reset (clears all entries)
//   in_v          ID instruction is real and writes a register
//   in_rd         ID destination register
//   in_ld         ID instruction is a load
//   insert        a bubble enters ID/EX this cycle (stall or redirect)
//   ex, mem, wb   registered tracker entries
// -----------------------------------------------------------------------------
module dst_tracker
  import mips_pkg::*;
(
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   in_v,
  input  logic [MIPS_REG_AW-1:0] in_rd,
  input  logic                   in_ld,
  input  logic                   insert,
  output trk_entry_t             ex,
  output trk_entry_t             mem,
  output trk_entry_t             wb
);

  always_ff @(posedge clk) begin
    if (rst) begin
      ex  <= '0;
      mem <= '0;
      wb  <= '0;
    end else begin
      ex  <= make_entry(in_v & ~insert, in_rd, in_ld);
      mem <= ex;
      wb  <= mem;
    end
  end

endmodule

// File: rtl/hazard_stall_ctrl.sv
// -----------------------------------------------------------------------------
// hazard_stall_ctrl
// Pipeline interlock controller for the 5-stage MIPS (IF/ID/EX/MEM/WB).
// Compares the ID-stage source reads against the destinations in flight in
// EX/MEM/WB, stalls IF/ID and inserts bubbles into ID/EX, and flushes IF/ID on
// a taken branch or jump resolved in EX.
//
// Build option: define FORWARDING_EN to enable the forwarding network. Then only
// load-use hazards stall (one cycle) and fwd_a/fwd_b select MEM/WB sources.
// Without it, every RAW hazard on an EX or MEM writer stalls and the forward
// selects are tied to FWD_REG. A WB writer never stalls: the register file
// writes in the first half-cycle and reads in the second.
//
// id_valid qualifies every ID-side input: when it is low the remaining id_*
// inputs are ignored and the ID slot neither matches nor enters the tracker.
// There is no backpressure handshake; all outputs are combinational from the
// registered tracker plus ID inputs, so a hazard stalls in the same cycle.
//
// Ports:
//   clk, rst        clock, synchronous active-high reset
//   id_valid        ID holds a real instruction
//   id_rs, id_rt    ID source registers
//   id_re1, id_re2  ID instruction reads rs / rt
//   id_we, id_rd    ID instruction writes register id_rd
//   id_is_load      ID instruction is a load
//   ex_redirect     branch taken / jump resolved in EX (wins over stall)
//   pc_we, ifid_we  PC and IF/ID write enables
//   ifid_flush      clear IF/ID to NOP
//   idex_bubble     load NOP into ID/EX
//   fwd_a, fwd_b    rs / rt forward select (FWD_REG, FWD_MEM, FWD_WB)
//   stall_cnt       saturating count of stall cycles not overridden by redirect
// REG_AW must equal mips_pkg::MIPS_REG_AW (tracker records are 32-register).
// -----------------------------------------------------------------------------
module hazard_stall_ctrl
  import mips_pkg::*;
#(
  parameter int REG_AW = 5,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              id_valid,
  input  logic [REG_AW-1:0] id_rs,
  input  logic [REG_AW-1:0] id_rt,
  input  logic              id_re1,
  input  logic              id_re2,
  input  logic              id_we,
  input  logic [REG_AW-1:0] id_rd,
  input  logic              id_is_load,
  input  logic              ex_redirect,
  output logic              pc_we,
  output logic              ifid_we,
  output logic              ifid_flush,
  output logic              idex_bubble,
  output logic [1:0]        fwd_a,
  output logic [1:0]        fwd_b,
  output logic [CNT_W-1:0]  stall_cnt
);

  trk_entry_t ex;
  trk_entry_t mem;
  trk_entry_t wb;

  logic match_ex;
  logic match_mem;
  logic stall;
  logic count_en;

  dst_tracker u_tracker (
    .clk    (clk),
    .rst    (rst),
    .in_v   (id_valid & id_we),
    .in_rd  (id_rd),
    .in_ld  (id_is_load),
    .insert (idex_bubble),
    .ex     (ex),
    .mem    (mem),
    .wb     (wb)
  );

  // Entry e holds a value the ID instruction actually reads. Entries for $0
  // are stored invalid, so no explicit rd!=0 check is needed here.
  function automatic logic reads_entry(input trk_entry_t        e,
                                       input logic              re1,
                                       input logic              re2,
                                       input logic [REG_AW-1:0] rs,
                                       input logic [REG_AW-1:0] rt);
    return e.v & ((re1 & (rs == e.rd)) | (re2 & (rt == e.rd)));
  endfunction

`ifdef FORWARDING_EN
  // MEM holds the younger result, so it wins when MEM and WB write the same rd.
  function automatic logic [1:0] fwd_sel(input trk_entry_t        m,
                                         input trk_entry_t        w,
                                         input logic [REG_AW-1:0] src);
    if (m.v && (m.rd == src)) return FWD_MEM;
    if (w.v && (w.rd == src)) return FWD_WB;
    return FWD_REG;
  endfunction
`endif

  always_comb begin
    match_ex    = id_valid & reads_entry(ex,  id_re1, id_re2, id_rs, id_rt);
    match_mem   = id_valid & reads_entry(mem, id_re1, id_re2, id_rs, id_rt);
`ifdef FORWARDING_EN
    stall       = match_ex & ex.ld;
    fwd_a       = fwd_sel(mem, wb, id_rs);
    fwd_b       = fwd_sel(mem, wb, id_rt);
`else
    stall       = match_ex | match_mem;
    fwd_a       = FWD_REG;
    fwd_b       = FWD_REG;
`endif
    pc_we       = 1'b1;
    ifid_we     = 1'b1;
    ifid_flush  = 1'b0;
    idex_bubble = 1'b0;
    if (ex_redirect) begin
      // The stalled ID instruction is on the wrong path anyway: flush it and
      // let the fetch of the redirect target proceed.
      ifid_flush  = 1'b1;
      idex_bubble = 1'b1;
    end else if (stall) begin
      pc_we       = 1'b0;
      ifid_we     = 1'b0;
      idex_bubble = 1'b1;
    end
    count_en    = stall & ~ex_redirect;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      stall_cnt <= '0;
    end else if (count_en && (stall_cnt != '1)) begin
      stall_cnt <= stall_cnt + 1'b1;
    end
  end

  // Tracker fields that this build does not consult.
  logic unused_sink;
  assign unused_sink = ^{mem.ld, wb};

endmodule

// File: tb/tb_hazard_stall_ctrl.sv
module tb_hazard_stall_ctrl;
  import mips_pkg::*;

  // Narrow counter so saturation is reached in a few thousand cycles.
  localparam int CW = 10;
  localparam int EW = 8 + CW;

  logic          clk = 1'b0;
  logic          rst;
  logic          id_valid, id_re1, id_re2, id_we, id_is_load, ex_redirect;
  logic [4:0]    id_rs, id_rt, id_rd;
  logic          pc_we, ifid_we, ifid_flush, idex_bubble;
  logic [1:0]    fwd_a, fwd_b;
  logic [CW-1:0] stall_cnt;

  hazard_stall_ctrl #(.REG_AW(5), .CNT_W(CW)) dut (
    .clk(clk), .rst(rst), .id_valid(id_valid), .id_rs(id_rs), .id_rt(id_rt),
    .id_re1(id_re1), .id_re2(id_re2), .id_we(id_we), .id_rd(id_rd),
    .id_is_load(id_is_load), .ex_redirect(ex_redirect), .pc_we(pc_we),
    .ifid_we(ifid_we), .ifid_flush(ifid_flush), .idex_bubble(idex_bubble),
    .fwd_a(fwd_a), .fwd_b(fwd_b), .stall_cnt(stall_cnt)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- instruction model ----------------
  typedef struct {
    logic       v;
    logic [4:0] rs, rt, rd;
    logic       re1, re2, we, ld;
  } ins_t;

  function automatic ins_t mk(input logic [5:0] op, input logic [4:0] rs,
                              input logic [4:0] rt, input logic [4:0] rd);
    ins_t i;
    i.v = 1'b1; i.rs = rs; i.rt = rt; i.rd = 5'd0;
    i.re1 = 1'b0; i.re2 = 1'b0; i.we = 1'b0; i.ld = 1'b0;
    case (op)
      OP_RTYPE:       begin i.re1 = 1; i.re2 = 1; i.we = 1; i.rd = rd; end
      OP_ADDI:        begin i.re1 = 1; i.we = 1; i.rd = rt; end
      OP_LW:          begin i.re1 = 1; i.we = 1; i.ld = 1; i.rd = rt; end
      OP_SW:          begin i.re1 = 1; i.re2 = 1; end
      OP_BEQ, OP_BNE: begin i.re1 = 1; i.re2 = 1; end
      OP_JAL:         begin i.we = 1; i.rd = 5'd31; end
      default:        ; // J: no register traffic
    endcase
    return i;
  endfunction

  function automatic ins_t nop();
    ins_t i;
    i.v = 0; i.rs = 0; i.rt = 0; i.rd = 0;
    i.re1 = 0; i.re2 = 0; i.we = 0; i.ld = 0;
    return i;
  endfunction

  // ---------------- reference model ----------------
  // Writers are logged with the cycle they entered EX; age 0 = EX, 1 = MEM,
  // 2 = WB.
  typedef struct { int tag; logic [4:0] rd; logic ld; } wr_t;
  wr_t  wr_q[$];
  int   cyc;
  int   m_cnt;
  int   n_stalls;
  ins_t cur;
  logic cur_redir, cur_rst, cur_stall;

  function automatic int find_wr(input logic [4:0] r, input int age);
    foreach (wr_q[k]) if (wr_q[k].rd == r && (cyc - wr_q[k].tag) == age) return k;
    return -1;
  endfunction

  function automatic logic hits(input ins_t i, input int age, input logic need_ld);
    int a, b;
    logic h;
    a = i.re1 ? find_wr(i.rs, age) : -1;
    b = i.re2 ? find_wr(i.rt, age) : -1;
    h = 1'b0;
    if (a >= 0 && (!need_ld || wr_q[a].ld)) h = 1'b1;
    if (b >= 0 && (!need_ld || wr_q[b].ld)) h = 1'b1;
    return h;
  endfunction

  function automatic logic model_stall(input ins_t i);
    if (!i.v) return 1'b0;
`ifdef FORWARDING_EN
    return hits(i, 0, 1'b1);
`else
    return hits(i, 0, 1'b0) | hits(i, 1, 1'b0);
`endif
  endfunction

  function automatic logic [1:0] model_fwd(input logic [4:0] r);
`ifdef FORWARDING_EN
    if (find_wr(r, 1) >= 0) return 2'd1;
    if (find_wr(r, 2) >= 0) return 2'd2;
`endif
    return 2'd0;
  endfunction

  task automatic model_edge();
    cyc++;
    if (cur_rst) begin
      wr_q.delete();
      m_cnt = 0;
    end else begin
      if (cur_stall && !cur_redir && m_cnt < (1 << CW) - 1) m_cnt++;
      if (cur.v && cur.we && cur.rd != 0 && !cur_stall && !cur_redir)
        wr_q.push_back('{cyc, cur.rd, cur.ld});
      while (wr_q.size() > 0 && (cyc - wr_q[0].tag) > 2) void'(wr_q.pop_front());
    end
  endtask

  // ---------------- scoreboard ----------------
  logic [EW-1:0] exp_q[$];
  int n_vec = 0;
  int n_bad = 0;

  always @(negedge clk) begin
    logic [EW-1:0] got, exp;
    if (exp_q.size() > 0) begin
      exp = exp_q.pop_front();
      got = {pc_we, ifid_we, ifid_flush, idex_bubble, fwd_a, fwd_b, stall_cnt};
      n_vec++;
      if (got !== exp)begin
        n_bad++;
        $display("FAIL outputs cyc=%0d got pc/ifid/flush/bubble=%b fwd_a=%0d fwd_b=%0d cnt=%0d, expected %b %0d %0d %0d",
                 cyc, got[EW-1:EW-4], got[EW-5:EW-6], got[EW-7:EW-8], got[CW-1:0],
                 exp[EW-1:EW-4], exp[EW-5:EW-6], exp[EW-7:EW-8], exp[CW-1:0]);
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic step(input ins_t i, input logic redir, input logic r);
    logic [3:0] ctl;
    @(posedge clk);
    model_edge();
    #1;
    cur = i; cur_redir = redir; cur_rst = r;
    rst = r; ex_redirect = redir;
    id_valid = i.v; id_rs = i.rs; id_rt = i.rt; id_rd = i.rd;
    id_re1 = i.re1; id_re2 = i.re2; id_we = i.we; id_is_load = i.ld;
    cur_stall = model_stall(i);
    if (redir)          ctl = 4'b1111;
    else if (cur_stall) ctl = 4'b0001;
    else                ctl = 4'b1100;
    if (cur_stall && !redir) n_stalls++;
    exp_q.push_back({ctl, model_fwd(i.rs), model_fwd(i.rt), m_cnt[CW-1:0]});
  endtask

  // Hold the instruction in ID for as long as the model says it is stalled.
  task automatic issue(input ins_t i);
    int g;
    g = 0;
    do begin
      step(i, 1'b0, 1'b0);
      g++;
    end while (cur_stall && g < 6);
  endtask

  task automatic drain(input int n);
    repeat (n) issue(nop());
  endtask

  // ---------------- stimulus ----------------
  logic [5:0] ops [8];
  ins_t       ri, sw_nore2;

  initial begin
    ops = '{OP_RTYPE, OP_ADDI, OP_LW, OP_SW, OP_BEQ, OP_BNE, OP_J, OP_JAL};
    rst = 1'b1; ex_redirect = 0; id_valid = 0; id_rs = 0; id_rt = 0; id_rd = 0;
    id_re1 = 0; id_re2 = 0; id_we = 0; id_is_load = 0;
    cur = nop(); cur_redir = 0; cur_rst = 1; cur_stall = 0;
    cyc = 0; m_cnt = 0; n_stalls = 0;

    step(nop(), 0, 1);
    step(nop(), 0, 1);
    drain(2);

    // load-use: lw $5,0($1); add $6,$5,$7
    issue(mk(OP_LW, 5'd1, 5'd5, 5'd0));
    issue(mk(OP_RTYPE, 5'd5, 5'd7, 5'd6));
    drain(3);

    // writer already in WB: no stall
    issue(mk(OP_LW, 5'd1, 5'd4, 5'd0));
    drain(2);
    issue(mk(OP_RTYPE, 5'd4, 5'd4, 5'd6));
    drain(3);

    // $0 is never a hazard
    issue(mk(OP_RTYPE, 5'd1, 5'd2, 5'd0));
    issue(mk(OP_RTYPE, 5'd0, 5'd0, 5'd3));
    drain(3);

    // sw reading rt=$8 after addi $8, then the same rt with re2 off
    issue(mk(OP_ADDI, 5'd2, 5'd8, 5'd0));
    issue(mk(OP_SW, 5'd9, 5'd8, 5'd0));
    drain(3);
    issue(mk(OP_ADDI, 5'd2, 5'd8, 5'd0));
    sw_nore2 = mk(OP_SW, 5'd9, 5'd8, 5'd0);
    sw_nore2.re2 = 1'b0;
    issue(sw_nore2);
    drain(3);

    // stall and redirect in the same cycle
    issue(mk(OP_LW, 5'd1, 5'd5, 5'd0));
    step(mk(OP_RTYPE, 5'd5, 5'd7, 5'd6), 1'b1, 1'b0);
    drain(3);

    // reset asserted mid-stall
    issue(mk(OP_LW, 5'd1, 5'd5, 5'd0));
    step(mk(OP_RTYPE, 5'd5, 5'd7, 5'd6), 1'b0, 1'b1);
    step(mk(OP_RTYPE, 5'd5, 5'd7, 5'd6), 1'b0, 1'b0);
    drain(3);

    // random traffic on a small register set to force frequent hazards
    repeat (600) begin
      ri = mk(ops[$urandom_range(0, 7)], 5'($urandom_range(0, 3)),
              5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)));
      if ($urandom_range(0, 7) == 0) ri.v = 1'b0;
      step(ri, $urandom_range(0, 9) == 0, $urandom_range(0, 99) == 0);
    end

    // counter saturation: self-dependent lw $5,0($5) stalls on every reissue
    step(nop(), 0, 1);
    n_stalls = 0;
    while (n_stalls < (1 << CW) + 5) issue(mk(OP_LW, 5'd5, 5'd5, 5'd0));
    drain(3);

    @(negedge clk);
    #1;
    n_vec++;
    if (exp_q.size() != 0) begin
      n_bad++;
      $display("FAIL scoreboard_drain: %0d entries left, expected 0", exp_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
